// File: rtl/spi_rx_decoder_pkg.sv
// ============================================================================
// spi_rx_decoder_pkg : shared encodings for the SPI receive-side decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_rx_decoder_pkg;
  localparam logic MODE_DAC = 1'b0;
  localparam logic MODE_ADC = 1'b1;

  localparam int POLL_BIT = 31;
  localparam int EOC_BIT  = 23;
  localparam int DMY_BIT  = 22;
  localparam int SIG_BIT  = 21;
  localparam int MSB_BIT  = 20;
  localparam int DATA_LSB = 5;
  localparam int ADC_W    = MSB_BIT - DATA_LSB + 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RX = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/spi_rx_decoder_if.sv
// ============================================================================
// spi_rx_decoder_if : tx/rx pairing inputs and decoded result outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_rx_decoder_if #(
  parameter int CNT_W = 8
);
  logic                                   i_MODE;
  logic                                   i_txValid;
  logic [31:0]                            i_txData;
  logic                                   i_rxValid;
  logic [31:0]                            i_RX;
  logic                                   o_resultValid;
  logic [spi_rx_decoder_pkg::ADC_W-1:0]   o_adcData;
  logic                                   o_overRange;
  logic                                   o_underRange;
  logic                                   o_eocReady;
  logic                                   o_echoOk;
  logic                                   o_echoErr;
  logic                                   o_seqErr;
  logic                                   o_fmtErr;
  logic [CNT_W-1:0]                       o_adcCount;
  logic [CNT_W-1:0]                       o_mismatchCount;

  modport master (
    output i_MODE, i_txValid, i_txData, i_rxValid, i_RX,
    input  o_resultValid, o_adcData, o_overRange, o_underRange, o_eocReady,
           o_echoOk, o_echoErr, o_seqErr, o_fmtErr, o_adcCount, o_mismatchCount
  );

  modport slave (
    input  i_MODE, i_txValid, i_txData, i_rxValid, i_RX,
    output o_resultValid, o_adcData, o_overRange, o_underRange, o_eocReady,
           o_echoOk, o_echoErr, o_seqErr, o_fmtErr, o_adcCount, o_mismatchCount
  );
endinterface

`default_nettype wire

// File: rtl/spi_rx_decoder_ltc2494_word_decode.sv
// ============================================================================
// ltc2494_word_decode : combinational split of an LTC2494 output word
// Rev 1.0
// ============================================================================
`default_nettype none

module ltc2494_word_decode
  import spi_rx_decoder_pkg::*;
(
  input  wire logic [EOC_BIT:DATA_LSB] i_word,
  output logic      [ADC_W-1:0]        o_data,
  output logic                         o_overRange,
  output logic                         o_underRange,
  output logic                         o_eoc,
  output logic                         o_dmy
);
  // Inverting SIG turns the offset-binary code into two's complement.
  assign o_data       = {~i_word[SIG_BIT], i_word[MSB_BIT:DATA_LSB]};
  assign o_overRange  = i_word[SIG_BIT] & i_word[MSB_BIT];
  assign o_underRange = ~i_word[SIG_BIT] & ~i_word[MSB_BIT];
  assign o_eoc        = ~i_word[EOC_BIT];
  assign o_dmy        = i_word[DMY_BIT];
endmodule

`default_nettype wire

// File: rtl/spi_rx_decoder.sv
// ============================================================================
// spi_rx_decoder : pairs command words with MISO words; DAC echo / ADC decode
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_rx_decoder
  import spi_rx_decoder_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 8
)(
  input  wire logic           clk,
  input  wire logic           rst,
  spi_rx_decoder_if.slave     bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [31:0]        cur_q, cur_d;
  logic [EOC_BIT:0]   prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               mode_q, mode_d;
  logic               result_valid_q, result_valid_d;
  logic [ADC_W-1:0]   adc_data_q, adc_data_d;
  logic               over_q, over_d;
  logic               under_q, under_d;
  logic               eoc_ready_q, eoc_ready_d;
  logic               echo_ok_q, echo_ok_d;
  logic               echo_err_q, echo_err_d;
  logic               seq_err_q, seq_err_d;
  logic               fmt_err_q, fmt_err_d;
  logic [CNT_W-1:0]   adc_count_q, adc_count_d;
  logic [CNT_W-1:0]   mis_count_q, mis_count_d;

  logic [ADC_W-1:0]   w_data;
  logic               w_over, w_under, w_eoc, w_dmy;
  logic               do_decode;
  logic               mode_chg;

  ltc2494_word_decode u_word_decode (
    .i_word       (bus.i_RX[EOC_BIT:DATA_LSB]),
    .o_data       (w_data),
    .o_overRange  (w_over),
    .o_underRange (w_under),
    .o_eoc        (w_eoc),
    .o_dmy        (w_dmy)
  );

  assign mode_chg = (bus.i_MODE != mode_q);

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    prev_d         = prev_q;
    prev_valid_d   = prev_valid_q;
    timer_d        = timer_q;
    mode_d         = bus.i_MODE;
    result_valid_d = 1'b0;
    adc_data_d     = adc_data_q;
    over_d         = over_q;
    under_d        = under_q;
    eoc_ready_d    = 1'b0;
    echo_ok_d      = 1'b0;
    echo_err_d     = 1'b0;
    seq_err_d      = seq_err_q;
    fmt_err_d      = fmt_err_q;
    adc_count_d    = adc_count_q;
    mis_count_d    = mis_count_q;
    do_decode      = 1'b0;

    // A mode switch invalidates any frame in flight; it is not an error.
    if (mode_chg) begin
      prev_valid_d = 1'b0;
      state_d      = ST_IDLE;
      timer_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_rxValid) seq_err_d = 1'b1;
          if (bus.i_txValid) begin
            cur_d   = bus.i_txData;
            timer_d = '0;
            state_d = ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (bus.i_rxValid) begin
            do_decode = 1'b1;
            state_d   = ST_IDLE;
            if (bus.i_txValid) begin
              cur_d   = bus.i_txData;
              timer_d = '0;
              state_d = ST_WAIT_RX;
            end
          end else if (bus.i_txValid) begin
            seq_err_d = 1'b1;
            cur_d     = bus.i_txData;
            timer_d   = '0;
          end else if (timer_q == TMR_W'(TIMEOUT)) begin
            seq_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_decode) begin
      if (bus.i_MODE == MODE_DAC) begin
        if (prev_valid_q) begin
          if (bus.i_RX[EOC_BIT:0] == prev_q) begin
            echo_ok_d = 1'b1;
          end else begin
            echo_err_d = 1'b1;
            if (mis_count_q != {CNT_W{1'b1}}) mis_count_d = mis_count_q + 1'b1;
          end
        end
        prev_d       = cur_q[EOC_BIT:0];
        prev_valid_d = 1'b1;
      end else if (cur_q[POLL_BIT]) begin
        eoc_ready_d = w_eoc;
      end else if (w_eoc) begin
        result_valid_d = 1'b1;
        adc_data_d     = w_data;
        over_d         = w_over;
        under_d        = w_under;
        adc_count_d    = adc_count_q + 1'b1;
        if (w_dmy) fmt_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cur_q          <= '0;
      prev_q         <= '0;
      prev_valid_q   <= 1'b0;
      timer_q        <= '0;
      mode_q         <= 1'b0;
      result_valid_q <= 1'b0;
      adc_data_q     <= '0;
      over_q         <= 1'b0;
      under_q        <= 1'b0;
      eoc_ready_q    <= 1'b0;
      echo_ok_q      <= 1'b0;
      echo_err_q     <= 1'b0;
      seq_err_q      <= 1'b0;
      fmt_err_q      <= 1'b0;
      adc_count_q    <= '0;
      mis_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      prev_q         <= prev_d;
      prev_valid_q   <= prev_valid_d;
      timer_q        <= timer_d;
      mode_q         <= mode_d;
      result_valid_q <= result_valid_d;
      adc_data_q     <= adc_data_d;
      over_q         <= over_d;
      under_q        <= under_d;
      eoc_ready_q    <= eoc_ready_d;
      echo_ok_q      <= echo_ok_d;
      echo_err_q     <= echo_err_d;
      seq_err_q      <= seq_err_d;
      fmt_err_q      <= fmt_err_d;
      adc_count_q    <= adc_count_d;
      mis_count_q    <= mis_count_d;
    end
  end

  assign bus.o_resultValid   = result_valid_q;
  assign bus.o_adcData       = adc_data_q;
  assign bus.o_overRange     = over_q;
  assign bus.o_underRange    = under_q;
  assign bus.o_eocReady      = eoc_ready_q;
  assign bus.o_echoOk        = echo_ok_q;
  assign bus.o_echoErr       = echo_err_q;
  assign bus.o_seqErr        = seq_err_q;
  assign bus.o_fmtErr        = fmt_err_q;
  assign bus.o_adcCount      = adc_count_q;
  assign bus.o_mismatchCount = mis_count_q;
endmodule

`default_nettype wire

// File: tb/tb_spi_rx_decoder.sv
// ============================================================================
// tb_spi_rx_decoder : scenario tasks checked against a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_rx_decoder;
  localparam int TO = 64;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_rx_decoder_if #(.CNT_W(CW)) bus ();

  spi_rx_decoder #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level reference model state
  logic        m_mode;
  logic [23:0] m_prev;
  bit          m_pv;
  int          m_mis, m_cnt;
  bit          m_seq, m_fmt, m_over, m_under;
  logic [16:0] m_data;
  bit          e_rv, e_eoc, e_ok, e_err;

  function automatic logic [40:0] all_outs();
    return {bus.o_resultValid, bus.o_adcData, bus.o_overRange, bus.o_underRange,
            bus.o_eocReady, bus.o_echoOk, bus.o_echoErr, bus.o_seqErr, bus.o_fmtErr,
            bus.o_adcCount, bus.o_mismatchCount};
  endfunction

  task automatic model_frame(input logic [31:0] tx, input logic [31:0] rx);
    logic [16:0] raw;
    e_rv = 0; e_eoc = 0; e_ok = 0; e_err = 0;
    if (m_mode == 1'b0) begin
      if (m_pv) begin
        if (rx[23:0] == m_prev) e_ok = 1;
        else begin
          e_err = 1;
          if (m_mis < 255) m_mis++;
        end
      end
      m_prev = tx[23:0];
      m_pv   = 1;
    end else if (tx[31]) begin
      e_eoc = !rx[23];
    end else if (!rx[23]) begin
      raw     = 17'((rx >> 5) & 32'h1FFFF);
      m_data  = raw + 17'h10000;
      m_over  = (raw >= 17'h18000);
      m_under = (raw <  17'h08000);
      e_rv    = 1;
      m_cnt   = (m_cnt + 1) % 256;
      if (rx[22]) m_fmt = 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx(input logic [31:0] d);
    bus.i_txValid = 1'b1; bus.i_txData = d;
    @(negedge clk);
    bus.i_txValid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [31:0] d);
    bus.i_rxValid = 1'b1; bus.i_RX = d;
    @(negedge clk);
    bus.i_rxValid = 1'b0;
  endtask

  task automatic do_reset(input logic mode);
    rst = 1'b1;
    bus.i_txValid = 0; bus.i_rxValid = 0; bus.i_txData = '0; bus.i_RX = '0;
    bus.i_MODE = mode;
    idle(2);
    rst = 1'b0;
    idle(2);
    m_mode = mode; m_pv = 0; m_prev = '0; m_mis = 0; m_cnt = 0;
    m_seq = 0; m_fmt = 0; m_over = 0; m_under = 0; m_data = '0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++; if (all_outs() !== 41'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
  endtask

  task automatic test_dac_echo;
    do_reset(1'b0);
    pulse_tx(32'h00289B7E); pulse_rx($urandom); model_frame(32'h00289B7E, 32'h0);
    checks++; if ({bus.o_echoOk, bus.o_echoErr} !== 2'b00) begin failures++; $display("FAIL dac_first_nostrobe got=%b exp=00", {bus.o_echoOk, bus.o_echoErr}); end
    pulse_tx(32'h00F00000); pulse_rx(32'h00289B7E); model_frame(32'h00F00000, 32'h00289B7E);
    checks++; if (bus.o_echoOk !== 1'b1) begin failures++; $display("FAIL dac_echo_ok got=%b exp=1", bus.o_echoOk); end
    checks++; if (bus.o_mismatchCount !== 8'd0) begin failures++; $display("FAIL dac_mis_zero got=%0d exp=0", bus.o_mismatchCount); end
  endtask

  task automatic test_dac_fail;
    logic [31:0] tx;
    do_reset(1'b0);
    pulse_tx(32'h00289B7E); pulse_rx(32'h0); model_frame(32'h00289B7E, 32'h0);
    pulse_tx(32'h00F00000); pulse_rx(32'h00289B7F); model_frame(32'h00F00000, 32'h00289B7F);
    checks++; if (bus.o_echoErr !== 1'b1) begin failures++; $display("FAIL dac_echo_err got=%b exp=1", bus.o_echoErr); end
    checks++; if (bus.o_mismatchCount !== 8'd1) begin failures++; $display("FAIL dac_mis_one got=%0d exp=1", bus.o_mismatchCount); end
    for (int i = 0; i < 300; i++) begin
      tx = $urandom;
      pulse_tx(tx); pulse_rx({8'h00, ~m_prev}); model_frame(tx, {8'h00, ~m_prev});
      checks++; if (bus.o_echoErr !== e_err) begin failures++; $display("FAIL dac_sat_err[%0d] got=%b exp=%b", i, bus.o_echoErr, e_err); end
    end
    checks++; if (bus.o_mismatchCount !== 8'hFF) begin failures++; $display("FAIL dac_mis_sat got=%h exp=ff", bus.o_mismatchCount); end
  endtask

  task automatic test_adc_poll_data;
    do_reset(1'b1);
    pulse_tx(32'h80800000); pulse_rx(32'h00000000);
    checks++; if ({bus.o_eocReady, bus.o_resultValid} !== 2'b10) begin failures++; $display("FAIL adc_poll got=%b exp=10", {bus.o_eocReady, bus.o_resultValid}); end
    pulse_tx(32'h00A08000); pulse_rx(32'h00300020);
    checks++; if (bus.o_resultValid !== 1'b1) begin failures++; $display("FAIL adc_rv got=%b exp=1", bus.o_resultValid); end
    checks++; if (bus.o_adcData !== 17'h08001) begin failures++; $display("FAIL adc_data1 got=%h exp=08001", bus.o_adcData); end
    checks++; if ({bus.o_overRange, bus.o_underRange} !== 2'b10) begin failures++; $display("FAIL adc_over got=%b exp=10", {bus.o_overRange, bus.o_underRange}); end
    pulse_tx(32'h00A08000); pulse_rx(32'h001FFFE0);
    checks++; if (bus.o_adcData !== 17'h1FFFF) begin failures++; $display("FAIL adc_data2 got=%h exp=1ffff", bus.o_adcData); end
    checks++; if ({bus.o_overRange, bus.o_underRange} !== 2'b00) begin failures++; $display("FAIL adc_inrange got=%b exp=00", {bus.o_overRange, bus.o_underRange}); end
    checks++; if (bus.o_adcCount !== 8'd2) begin failures++; $display("FAIL adc_count got=%0d exp=2", bus.o_adcCount); end
  endtask

  task automatic test_stale_fmt;
    pulse_tx(32'h00000000); pulse_rx(32'h00800000);
    checks++; if (bus.o_resultValid !== 1'b0) begin failures++; $display("FAIL stale_rv got=%b exp=0", bus.o_resultValid); end
    checks++; if (bus.o_adcCount !== 8'd2) begin failures++; $display("FAIL stale_count got=%0d exp=2", bus.o_adcCount); end
    checks++; if (bus.o_fmtErr !== 1'b0) begin failures++; $display("FAIL fmt_pre got=%b exp=0", bus.o_fmtErr); end
    pulse_tx(32'h00000000); pulse_rx(32'h00400000);
    checks++; if (bus.o_fmtErr !== 1'b1) begin failures++; $display("FAIL fmt_set got=%b exp=1", bus.o_fmtErr); end
    checks++; if ({bus.o_resultValid, bus.o_adcData, bus.o_underRange} !== {1'b1, 17'h10000, 1'b1}) begin failures++; $display("FAIL fmt_result got=%b/%h/%b exp=1/10000/1", bus.o_resultValid, bus.o_adcData, bus.o_underRange); end
    pulse_tx(32'h80000000); pulse_rx(32'h00800000);
    checks++; if (bus.o_eocReady !== 1'b0) begin failures++; $display("FAIL poll_busy got=%b exp=0", bus.o_eocReady); end
  endtask

  task automatic test_sequencing;
    do_reset(1'b1);
    pulse_rx(32'h00300020);
    checks++; if ({bus.o_seqErr, bus.o_resultValid} !== 2'b10) begin failures++; $display("FAIL seq_rx_no_tx got=%b exp=10", {bus.o_seqErr, bus.o_resultValid}); end
    do_reset(1'b1);
    pulse_tx(32'h00000000); idle(TO - 4);
    checks++; if (bus.o_seqErr !== 1'b0) begin failures++; $display("FAIL seq_pre_timeout got=%b exp=0", bus.o_seqErr); end
    idle(10);
    checks++; if (bus.o_seqErr !== 1'b1) begin failures++; $display("FAIL seq_timeout got=%b exp=1", bus.o_seqErr); end
    pulse_rx(32'h00300020);
    checks++; if ({bus.o_resultValid, bus.o_adcCount} !== {1'b0, 8'd0}) begin failures++; $display("FAIL seq_idle_after_to got=%b/%0d exp=0/0", bus.o_resultValid, bus.o_adcCount); end
    do_reset(1'b1);
    pulse_tx(32'h80000000); pulse_tx(32'h00000000);
    checks++; if (bus.o_seqErr !== 1'b1) begin failures++; $display("FAIL seq_double_tx got=%b exp=1", bus.o_seqErr); end
    pulse_rx(32'h00300020);
    checks++; if ({bus.o_resultValid, bus.o_adcData} !== {1'b1, 17'h08001}) begin failures++; $display("FAIL seq_second_tx_used got=%b/%h exp=1/08001", bus.o_resultValid, bus.o_adcData); end
  endtask

  task automatic test_mode_change;
    do_reset(1'b0);
    pulse_tx(32'h00111111); pulse_rx(32'h0); model_frame(32'h00111111, 32'h0);
    pulse_tx(32'h00222222);
    bus.i_MODE = 1'b1; idle(2); bus.i_MODE = 1'b0; idle(TO + 10);
    m_pv = 0;
    checks++; if (bus.o_seqErr !== 1'b0) begin failures++; $display("FAIL mode_abort_noseq got=%b exp=0", bus.o_seqErr); end
    pulse_tx(32'h00333333); pulse_rx(32'h00111111); model_frame(32'h00333333, 32'h00111111);
    checks++; if ({bus.o_echoOk, bus.o_echoErr} !== {e_ok, e_err}) begin failures++; $display("FAIL mode_nocompare got=%b exp=%b", {bus.o_echoOk, bus.o_echoErr}, {e_ok, e_err}); end
    pulse_tx(32'h00444444); pulse_rx(32'h00333333); model_frame(32'h00444444, 32'h00333333);
    checks++; if (bus.o_echoOk !== e_ok) begin failures++; $display("FAIL mode_resume got=%b exp=%b", bus.o_echoOk, e_ok); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tx_cur, tx_nxt, rx;
    do_reset(1'b0);
    tx_cur = $urandom;
    pulse_tx(tx_cur);
    for (int i = 0; i < 8; i++) begin
      tx_nxt = $urandom;
      rx = ($urandom_range(0, 1) == 1) ? {8'h00, m_prev} : $urandom;
      bus.i_txValid = 1'b1; bus.i_txData = tx_nxt; bus.i_rxValid = 1'b1; bus.i_RX = rx;
      @(negedge clk);
      bus.i_txValid = 1'b0; bus.i_rxValid = 1'b0;
      model_frame(tx_cur, rx);
      tx_cur = tx_nxt;
      checks++; if ({bus.o_echoOk, bus.o_echoErr, bus.o_seqErr} !== {e_ok, e_err, 1'b0}) begin failures++; $display("FAIL b2b[%0d] got=%b exp=%b", i, {bus.o_echoOk, bus.o_echoErr, bus.o_seqErr}, {e_ok, e_err, 1'b0}); end
    end
    pulse_rx({8'h00, m_prev}); model_frame(tx_cur, {8'h00, m_prev});
    checks++; if (bus.o_echoOk !== 1'b1) begin failures++; $display("FAIL b2b_last got=%b exp=1", bus.o_echoOk); end
  endtask

  task automatic test_random;
    logic [31:0] tx, rx;
    for (int r = 0; r < 4; r++) begin
      do_reset(1'(r % 2));
      for (int i = 0; i < 30; i++) begin
        tx = $urandom;
        rx = $urandom;
        if (m_mode == 1'b0 && $urandom_range(0, 1) == 1) rx[23:0] = m_prev;
        pulse_tx(tx); idle($urandom_range(0, 4)); pulse_rx(rx);
        model_frame(tx, rx);
        checks++; if (bus.o_resultValid !== e_rv) begin failures++; $display("FAIL rnd_rv got=%b exp=%b", bus.o_resultValid, e_rv); end
        checks++; if (bus.o_adcData !== m_data) begin failures++; $display("FAIL rnd_data got=%h exp=%h", bus.o_adcData, m_data); end
        checks++; if ({bus.o_overRange, bus.o_underRange} !== {m_over, m_under}) begin failures++; $display("FAIL rnd_range got=%b exp=%b", {bus.o_overRange, bus.o_underRange}, {m_over, m_under}); end
        checks++; if (bus.o_eocReady !== e_eoc) begin failures++; $display("FAIL rnd_eoc got=%b exp=%b", bus.o_eocReady, e_eoc); end
        checks++; if ({bus.o_echoOk, bus.o_echoErr} !== {e_ok, e_err}) begin failures++; $display("FAIL rnd_echo got=%b exp=%b", {bus.o_echoOk, bus.o_echoErr}, {e_ok, e_err}); end
        checks++; if ({bus.o_seqErr, bus.o_fmtErr} !== {m_seq, m_fmt}) begin failures++; $display("FAIL rnd_sticky got=%b exp=%b", {bus.o_seqErr, bus.o_fmtErr}, {m_seq, m_fmt}); end
        checks++; if (bus.o_adcCount !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", bus.o_adcCount, m_cnt); end
        checks++; if (bus.o_mismatchCount !== 8'(m_mis)) begin failures++; $display("FAIL rnd_mis got=%0d exp=%0d", bus.o_mismatchCount, m_mis); end
      end
    end
  endtask

  task automatic test_reset_midframe;
    do_reset(1'b1);
    pulse_tx(32'h00000000); pulse_rx(32'h00700020);
    pulse_rx(32'h0);
    checks++; if ({bus.o_seqErr, bus.o_fmtErr, bus.o_adcCount} !== {1'b1, 1'b1, 8'd1}) begin failures++; $display("FAIL pre_reset_state got=%b/%b/%0d exp=1/1/1", bus.o_seqErr, bus.o_fmtErr, bus.o_adcCount); end
    pulse_tx(32'h00000000);
    #2 rst = 1'b1;
    #1;
    checks++; if (all_outs() !== 41'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", all_outs()); end
    @(negedge clk);
    do_reset(1'b0);
  endtask

  initial begin
    bus.i_MODE = 0; bus.i_txValid = 0; bus.i_rxValid = 0; bus.i_txData = '0; bus.i_RX = '0;
    test_reset();
    test_dac_echo();
    test_dac_fail();
    test_adc_poll_data();
    test_stale_fmt();
    test_sequencing();
    test_mode_change();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/spi_rx_decoder.md
Name: spi_rx_decoder

Overview:
- Receive-side counterpart to the command word generator on the SPI master driver path.
- Pairs each transmitted 32-bit command word with the 32-bit MISO word returned for the same frame.
- DAC mode (LTC2668): checks the readback echo of the previous command.
- ADC mode (LTC2494): decodes the 24-bit conversion output into a signed result with range flags, and reports EOC poll status.

Parameters:
TIMEOUT, 4096, max clk cycles between tx capture and matching rx word before a sequence error
CNT_W, 8, width of the result and mismatch counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
i_MODE  input  1  0 = DAC, 1 = ADC (same encoding as the command generator)
i_txValid  input  1  one-cycle strobe: command word accepted by master driver
i_txData  input  32  command word sent; bit31 = 1 marks an ADC EOC-poll frame
i_rxValid  input  1  one-cycle strobe: MISO word for the frame is complete
i_RX  input  32  received word; payload in bits 23:0, MSB-first
o_resultValid  output  1  one-cycle strobe: o_adcData updated
o_adcData  output  17  signed ADC result
o_overRange  output  1  result flag, valid with o_resultValid
o_underRange  output  1  result flag, valid with o_resultValid
o_eocReady  output  1  one-cycle strobe: poll frame saw /EOC = 0
o_echoOk  output  1  one-cycle strobe: DAC echo matched
o_echoErr  output  1  one-cycle strobe: DAC echo mismatched
o_seqErr  output  1  sticky: tx/rx pairing violated or timeout
o_fmtErr  output  1  sticky: ADC DMY bit (i_RX[22]) = 1 on a data frame
o_adcCount  output  CNT_W  valid results, wraps
o_mismatchCount  output  CNT_W  DAC echo mismatches, saturates at all-ones

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0, FSM to IDLE.
  - r_cur, r_prev and prevValid cleared.
- FSM:
  - IDLE: on i_txValid, latch i_txData into r_cur and go to WAIT_RX. On i_rxValid without a prior tx, set o_seqErr and stay in IDLE; the word is discarded.
  - WAIT_RX: timer counts up from 0.
    - i_rxValid: decode for one cycle, then return to IDLE.
    - i_txValid before rx: set o_seqErr, overwrite r_cur, restart timer.
    - Timer reaches TIMEOUT: set o_seqErr, go to IDLE.
  - DECODE happens on the i_rxValid cycle. All result outputs are registered and appear the cycle after i_rxValid (latency 1).
  - i_txValid and i_rxValid in the same cycle while in WAIT_RX: complete the current frame, then latch the new tx and stay in WAIT_RX (back-to-back frames).
- DAC decode (i_MODE = 0):
  - If prevValid: compare i_RX[23:0] with r_prev[23:0]. Equal -> pulse o_echoOk; unequal -> pulse o_echoErr and increment o_mismatchCount (saturating).
  - Then r_prev <= r_cur and prevValid <= 1.
  - First frame after reset or after a mode change performs no compare and produces no strobe.
- ADC decode (i_MODE = 1):
  - Poll frame (r_cur[31] = 1): if i_RX[23] = 0, pulse o_eocReady; no result is produced.
  - Data frame (r_cur[31] = 0), only when i_RX[23] = 0:
    - Treat i_RX[21] as SIG and i_RX[20] as MSB.
    - o_adcData = {~i_RX[21], i_RX[20:5]}.
    - o_overRange = SIG & MSB; o_underRange = ~SIG & ~MSB.
    - Pulse o_resultValid and increment o_adcCount (wraps).
    - i_RX[22] = 1 additionally sets o_fmtErr; the result is still published.
  - Data frame with i_RX[23] = 1 (stale): no strobe, no count.
- Mode change: detected by registering i_MODE.
  - Clears prevValid.
  - If the FSM is in WAIT_RX, abort to IDLE without setting o_seqErr.
- Sticky flags clear only on reset. o_adcData holds its value between strobes.

Decomposition:
- Shared package:
  - Mode encodings DAC = 0, ADC = 1.
  - Bit positions: POLL_BIT = 31, EOC_BIT = 23, DMY_BIT = 22, SIG_BIT = 21, MSB_BIT = 20, DATA_LSB = 5.
  - FSM state encodings.
- One natural sub-module: ltc2494_word_decode (combinational 24-bit -> data, range flags, eoc, dmy), instantiated in the DECODE path.

Test Plan:
- DAC echo pass: tx 0x00289B7E/rx any, then tx 0x00F00000/rx 0x00289B7E -> no strobe on frame 1, o_echoOk on frame 2, o_mismatchCount = 0.
- DAC echo fail: same sequence with second rx 0x00289B7F -> o_echoErr once, o_mismatchCount = 1; 300 mismatches -> count holds 0xFF.
- ADC poll then data:
  - tx 0x80800000 / rx 0x00000000 -> o_eocReady.
  - tx 0x00A08000 / rx 0x00300020 (SIG=1, MSB=1) -> o_resultValid, o_adcData = 0x0_8001, o_overRange = 1.
  - rx 0x001FFFE0 -> o_adcData = 0x1FFFF, both range flags 0.
- Stale/format: data frame rx 0x00800000 -> no strobe, o_adcCount unchanged; rx 0x00400000 -> o_fmtErr = 1.
- Sequencing: rx without tx -> o_seqErr; tx with no rx for TIMEOUT cycles -> o_seqErr, FSM in IDLE; two tx before rx -> o_seqErr.
- Reset/mode: assert rst while in WAIT_RX -> all outputs 0 immediately; toggle i_MODE mid-frame -> abort, no o_seqErr, next DAC frame does no compare.
